// File: rtl/sp_bank_pkg.sv
// Shared defaults and helpers for the multi-bank stack pointer unit.
package sp_pkg;

  localparam int unsigned DEF_WIDTH     = 16;
  localparam int unsigned DEF_NUM_SP    = 2;
  localparam int unsigned DEF_STEP      = 1;
  localparam int unsigned DEF_LIMIT_LO  = 32'h0000_0100;
  localparam int unsigned DEF_LIMIT_HI  = 32'h0000_01FF;
  localparam int unsigned DEF_RESET_VAL = 32'h0000_01FF;

  // Bank select width; a single bank still needs a one-bit select port.
  function automatic int unsigned sel_width(input int unsigned num_sp);
    if (num_sp <= 32'd1) begin
      return 32'd1;
    end else begin
      return $clog2(num_sp);
    end
  endfunction

endpackage

// File: rtl/sp_bank_if.sv
// Command/readback bundle between the datapath control and the stack pointer bank.
interface sp_bank_if
  import sp_pkg::*;
#(
  parameter int unsigned WIDTH  = DEF_WIDTH,
  parameter int unsigned NUM_SP = DEF_NUM_SP,
  parameter int unsigned SEL_W  = sel_width(NUM_SP)
);

  logic [SEL_W-1:0]  sel;
  logic [WIDTH-1:0]  din;
  logic              write;
  logic              inc;
  logic              dec;
  logic              err_clr;
  logic              read_abus;
  logic              read_dbus;
  logic [WIDTH-1:0]  abus_out;
  logic [WIDTH-1:0]  dbus_out;
  logic [NUM_SP-1:0] err_hi;
  logic [NUM_SP-1:0] err_lo;

  modport master (
    output sel, din, write, inc, dec, err_clr, read_abus, read_dbus,
    input  abus_out, dbus_out, err_hi, err_lo
  );

  modport slave (
    input  sel, din, write, inc, dec, err_clr, read_abus, read_dbus,
    output abus_out, dbus_out, err_hi, err_lo
  );

endinterface

// File: rtl/sp_bank_reg.sv
// One stack pointer with bounds-checked step moves and sticky over/underflow flags.
module sp_reg
  import sp_pkg::*;
#(
  parameter int unsigned WIDTH     = DEF_WIDTH,
  parameter int unsigned STEP      = DEF_STEP,
  parameter int unsigned LIMIT_LO  = DEF_LIMIT_LO,
  parameter int unsigned LIMIT_HI  = DEF_LIMIT_HI,
  parameter int unsigned RESET_VAL = DEF_RESET_VAL
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             write,
  input  logic             inc,
  input  logic             dec,
  input  logic             err_clr,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] ptr,
  output logic             err_hi,
  output logic             err_lo
);

  // One extra bit keeps the carry/borrow of a step visible to the range check.
  localparam logic [WIDTH:0]   STEP_X = (WIDTH+1)'(STEP);
  localparam logic [WIDTH:0]   LO_X   = (WIDTH+1)'(LIMIT_LO);
  localparam logic [WIDTH:0]   HI_X   = (WIDTH+1)'(LIMIT_HI);
  localparam logic [WIDTH-1:0] RST_P  = WIDTH'(RESET_VAL);

  logic [WIDTH-1:0] ptr_r;
  logic             err_hi_r;
  logic             err_lo_r;
  logic [WIDTH-1:0] ptr_nxt_s;
  logic             hi_nxt_s;
  logic             lo_nxt_s;
  logic [WIDTH:0]   sum_s;
  logic [WIDTH:0]   diff_s;
  logic             inc_ok_s;
  logic             dec_ok_s;

  assign sum_s    = {1'b0, ptr_r} + STEP_X;
  assign diff_s   = {1'b0, ptr_r} - STEP_X;
  assign inc_ok_s = (sum_s <= HI_X);
  assign dec_ok_s = !diff_s[WIDTH] && (diff_s >= LO_X);

  // Next-state: clear first so a blocked move in the same cycle re-sets its flag.
  always_comb begin
    ptr_nxt_s = ptr_r;
    if (err_clr) begin
      hi_nxt_s = 1'b0;
      lo_nxt_s = 1'b0;
    end else begin
      hi_nxt_s = err_hi_r;
      lo_nxt_s = err_lo_r;
    end
    if (write) begin
      ptr_nxt_s = din;
    end else if (inc && dec) begin
      ptr_nxt_s = ptr_r;
    end else if (inc) begin
      if (inc_ok_s) begin
        ptr_nxt_s = sum_s[WIDTH-1:0];
      end else begin
        hi_nxt_s = 1'b1;
      end
    end else if (dec) begin
      if (dec_ok_s) begin
        ptr_nxt_s = diff_s[WIDTH-1:0];
      end else begin
        lo_nxt_s = 1'b1;
      end
    end else begin
      ptr_nxt_s = ptr_r;
    end
  end

  // Pointer and flag registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_r    <= RST_P;
      err_hi_r <= 1'b0;
      err_lo_r <= 1'b0;
    end else begin
      ptr_r    <= ptr_nxt_s;
      err_hi_r <= hi_nxt_s;
      err_lo_r <= lo_nxt_s;
    end
  end

  assign ptr    = ptr_r;
  assign err_hi = err_hi_r;
  assign err_lo = err_lo_r;

endmodule

// File: rtl/sp_bank.sv
// Multi-bank stack pointer unit: select decode, per-bank pointers and gated bus readback.
module sp_bank
  import sp_pkg::*;
#(
  parameter int unsigned WIDTH     = DEF_WIDTH,
  parameter int unsigned NUM_SP    = DEF_NUM_SP,
  parameter int unsigned STEP      = DEF_STEP,
  parameter int unsigned LIMIT_LO  = DEF_LIMIT_LO,
  parameter int unsigned LIMIT_HI  = DEF_LIMIT_HI,
  parameter int unsigned RESET_VAL = DEF_RESET_VAL
) (
  input logic        clk,
  input logic        reset,
  sp_bank_if.slave   bus
);

  logic              sel_ok_s;
  logic [NUM_SP-1:0] hit_s;
  logic [NUM_SP-1:0] err_hi_s;
  logic [NUM_SP-1:0] err_lo_s;
  logic [WIDTH-1:0]  ptr_s [NUM_SP];
  logic [WIDTH-1:0]  sel_ptr_s;

  // Out-of-range selects hit no bank, so ops, clears and reads all fall away.
  assign sel_ok_s = (32'(bus.sel) < 32'(NUM_SP));

  for (genvar i = 0; i < NUM_SP; i++) begin : g_bank
    assign hit_s[i] = sel_ok_s && (32'(bus.sel) == 32'(i));

    sp_reg #(
      .WIDTH     (WIDTH),
      .STEP      (STEP),
      .LIMIT_LO  (LIMIT_LO),
      .LIMIT_HI  (LIMIT_HI),
      .RESET_VAL (RESET_VAL)
    ) u_reg (
      .clk     (clk),
      .reset   (reset),
      .write   (bus.write   && hit_s[i]),
      .inc     (bus.inc     && hit_s[i]),
      .dec     (bus.dec     && hit_s[i]),
      .err_clr (bus.err_clr && hit_s[i]),
      .din     (bus.din),
      .ptr     (ptr_s[i]),
      .err_hi  (err_hi_s[i]),
      .err_lo  (err_lo_s[i])
    );
  end

  // One-hot AND-OR readback mux of the selected pointer.
  always_comb begin
    sel_ptr_s = {WIDTH{1'b0}};
    for (int i = 0; i < NUM_SP; i++) begin
      sel_ptr_s = sel_ptr_s | ({WIDTH{hit_s[i]}} & ptr_s[i]);
    end
  end

  assign bus.abus_out = bus.read_abus ? sel_ptr_s : {WIDTH{1'b0}};
  assign bus.dbus_out = bus.read_dbus ? sel_ptr_s : {WIDTH{1'b0}};
  assign bus.err_hi   = err_hi_s;
  assign bus.err_lo   = err_lo_s;

endmodule

// File: tb/tb_sp_bank.sv
// Directed table-driven bench for sp_bank: defaults, a 3-bank instance and an 8-bit variant.
module tb_sp_bank;
  import sp_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  sp_bank_if #(.WIDTH(16), .NUM_SP(2)) b2 ();
  sp_bank_if #(.WIDTH(16), .NUM_SP(3)) b3 ();
  sp_bank_if #(.WIDTH(8),  .NUM_SP(2)) b8 ();

  sp_bank #(.WIDTH(16), .NUM_SP(2), .STEP(1), .LIMIT_LO(32'h100), .LIMIT_HI(32'h1FF),
            .RESET_VAL(32'h1FF)) u_dut2 (.clk(clk), .reset(reset), .bus(b2));
  sp_bank #(.WIDTH(16), .NUM_SP(3), .STEP(1), .LIMIT_LO(32'h100), .LIMIT_HI(32'h1FF),
            .RESET_VAL(32'h1FF)) u_dut3 (.clk(clk), .reset(reset), .bus(b3));
  sp_bank #(.WIDTH(8), .NUM_SP(2), .STEP(2), .LIMIT_LO(32'h00), .LIMIT_HI(32'hFF),
            .RESET_VAL(32'hFE)) u_dut8 (.clk(clk), .reset(reset), .bus(b8));

  typedef struct {
    logic        rst;
    logic        sel;
    logic [15:0] din;
    logic        wr;
    logic        in;
    logic        de;
    logic        clr;
    logic        chk;
    logic [15:0] exp_p;
    logic [1:0]  exp_hi;
    logic [1:0]  exp_lo;
  } vec_t;

  vec_t vq[$];
  vec_t v;
  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle_all();
    b2.sel = 1'b0; b2.din = 16'h0; b2.write = 1'b0; b2.inc = 1'b0; b2.dec = 1'b0;
    b2.err_clr = 1'b0; b2.read_abus = 1'b0; b2.read_dbus = 1'b0;
    b3.sel = 2'd0; b3.din = 16'h0; b3.write = 1'b0; b3.inc = 1'b0; b3.dec = 1'b0;
    b3.err_clr = 1'b0; b3.read_abus = 1'b0; b3.read_dbus = 1'b0;
    b8.sel = 1'b0; b8.din = 8'h0; b8.write = 1'b0; b8.inc = 1'b0; b8.dec = 1'b0;
    b8.err_clr = 1'b0; b8.read_abus = 1'b0; b8.read_dbus = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle_all();
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    // rst sel din wr in de clr | chk exp_p exp_hi exp_lo
    vq.push_back('{1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h01FF, 2'b00, 2'b00});
    vq.push_back('{1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h01FF, 2'b00, 2'b00});
    vq.push_back('{1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h01FE, 2'b00, 2'b00});
    vq.push_back('{1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h01FD, 2'b00, 2'b00});
    vq.push_back('{1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h01FC, 2'b00, 2'b00});
    vq.push_back('{1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h01FF, 2'b00, 2'b00});
    vq.push_back('{1'b0, 1'b1, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 16'h01FF, 2'b10, 2'b00});
    vq.push_back('{1'b0, 1'b1, 16'h0100, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0100, 2'b10, 2'b00});
    vq.push_back('{1'b0, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0100, 2'b10, 2'b10});
    vq.push_back('{1'b0, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 16'h0100, 2'b00, 2'b10});
    vq.push_back('{1'b0, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0100, 2'b00, 2'b00});
    vq.push_back('{1'b0, 1'b0, 16'h0150, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0150, 2'b00, 2'b00});
    vq.push_back('{1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0150, 2'b00, 2'b00});
    vq.push_back('{1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0151, 2'b00, 2'b00});
    vq.push_back('{1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0100, 2'b00, 2'b00});
    vq.push_back('{1'b0, 1'b0, 16'h01FF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h01FF, 2'b00, 2'b00});
    vq.push_back('{1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h01FF, 2'b01, 2'b00});
    vq.push_back('{1'b0, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h01FF, 2'b01, 2'b00});
    vq.push_back('{1'b0, 1'b0, 16'h0050, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0050, 2'b01, 2'b00});
    vq.push_back('{1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0050, 2'b01, 2'b01});
    vq.push_back('{1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0051, 2'b01, 2'b01});
    vq.push_back('{1'b0, 1'b0, 16'h0300, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0300, 2'b00, 2'b00});
    vq.push_back('{1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0300, 2'b01, 2'b00});
    vq.push_back('{1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h02FF, 2'b01, 2'b00});
    vq.push_back('{1'b1, 1'b0, 16'h0180, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h01FF, 2'b00, 2'b00});
    vq.push_back('{1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h01FF, 2'b00, 2'b00});

    do_reset();

    // Reset state with read enables low, then each bank read back.
    #1;
    check("rst_abus_idle", 32'(b2.abus_out), 32'h0);
    check("rst_dbus_idle", 32'(b2.dbus_out), 32'h0);
    b2.read_abus = 1'b1;
    b2.sel = 1'b1;
    #1;
    check("rst_bank1", 32'(b2.abus_out), 32'h01FF);
    check("rst_err_hi", 32'(b2.err_hi), 32'h0);
    check("rst_err_lo", 32'(b2.err_lo), 32'h0);
    b2.read_abus = 1'b0;

    foreach (vq[k]) begin
      v = vq[k];
      reset = v.rst;
      b2.sel = v.sel; b2.din = v.din; b2.write = v.wr; b2.inc = v.in; b2.dec = v.de;
      b2.err_clr = v.clr; b2.read_abus = 1'b0; b2.read_dbus = 1'b0;
      tick();
      reset = 1'b0;
      b2.write = 1'b0; b2.inc = 1'b0; b2.dec = 1'b0; b2.err_clr = 1'b0;
      b2.sel = v.chk; b2.read_abus = 1'b1; b2.read_dbus = 1'b1;
      #1;
      check($sformatf("vec%0d_abus", k), 32'(b2.abus_out), 32'(v.exp_p));
      check($sformatf("vec%0d_dbus", k), 32'(b2.dbus_out), 32'(v.exp_p));
      check($sformatf("vec%0d_err_hi", k), 32'(b2.err_hi), 32'(v.exp_hi));
      check($sformatf("vec%0d_err_lo", k), 32'(b2.err_lo), 32'(v.exp_lo));
    end

    // A read in the same cycle as a dec sees the pre-edge pointer; dbus alone afterwards.
    idle_all();
    b2.sel = 1'b0; b2.dec = 1'b1; b2.read_abus = 1'b1;
    #1;
    check("same_cycle_read", 32'(b2.abus_out), 32'h01FF);
    tick();
    b2.dec = 1'b0; b2.read_abus = 1'b0; b2.read_dbus = 1'b1;
    #1;
    check("dbus_only_abus", 32'(b2.abus_out), 32'h0);
    check("dbus_only_dbus", 32'(b2.dbus_out), 32'h01FE);

    // Three-bank instance: select 3 is out of range and must be inert.
    idle_all();
    b3.sel = 2'd0; b3.inc = 1'b1;
    tick();
    b3.inc = 1'b0;
    check("b3_inc_blocked_flag", 32'(b3.err_hi), 32'h1);
    b3.sel = 2'd3; b3.din = 16'h0123; b3.write = 1'b1; b3.err_clr = 1'b1;
    b3.read_abus = 1'b1; b3.read_dbus = 1'b1;
    #1;
    check("b3_bad_sel_abus", 32'(b3.abus_out), 32'h0);
    check("b3_bad_sel_dbus", 32'(b3.dbus_out), 32'h0);
    tick();
    b3.write = 1'b0; b3.err_clr = 1'b0; b3.sel = 2'd0;
    #1;
    check("b3_bank0_kept", 32'(b3.abus_out), 32'h01FF);
    check("b3_flag_kept", 32'(b3.err_hi), 32'h1);
    b3.sel = 2'd2; b3.dec = 1'b1;
    tick();
    b3.dec = 1'b0;
    #1;
    check("b3_bank2_dec", 32'(b3.abus_out), 32'h01FE);
    b3.sel = 2'd1;
    #1;
    check("b3_bank1_kept", 32'(b3.abus_out), 32'h01FF);

    // 8-bit variant, STEP=2: carry-out and borrow are both blocked.
    do_reset();
    b8.sel = 1'b0; b8.read_abus = 1'b1;
    #1;
    check("b8_reset", 32'(b8.abus_out), 32'hFE);
    b8.inc = 1'b1;
    tick();
    b8.inc = 1'b0;
    check("b8_inc_carry_ptr", 32'(b8.abus_out), 32'hFE);
    check("b8_inc_carry_flag", 32'(b8.err_hi), 32'h1);
    b8.din = 8'h01; b8.write = 1'b1;
    tick();
    b8.write = 1'b0;
    check("b8_write", 32'(b8.abus_out), 32'h01);
    b8.dec = 1'b1;
    tick();
    b8.dec = 1'b0;
    check("b8_dec_borrow_ptr", 32'(b8.abus_out), 32'h01);
    check("b8_dec_borrow_flag", 32'(b8.err_lo), 32'h1);
    b8.inc = 1'b1;
    tick();
    b8.inc = 1'b0;
    check("b8_inc_ok", 32'(b8.abus_out), 32'h03);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
